// File: rtl/boa_uart_tx_arbiter.sv
// Round-robin, line-locking arbiter sharing one UART TX data-register write port among NREQ byte streams.
// Optional idle timeout inside a lock: define BOA_UART_ARB_TIMEOUT_EN.
module boa_uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_we,
  output logic [7:0]        uart_wdata,
  input  logic              uart_ready,
  output logic [NREQ-1:0]   grant,
  output logic              locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] NEWLINE    = 8'h0A;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  if (NREQ < 1 || NREQ > 16 || MAX_BURST < 1 || MAX_BURST > 255 ||
      IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_param_check
    $error("boa_uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   owner_reg, owner_next;
  logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [7:0]      burst_cnt_reg, burst_cnt_next;
  logic            out_valid_reg, out_valid_next;
  logic [7:0]      out_data_reg, out_data_next;
`ifdef BOA_UART_ARB_TIMEOUT_EN
  logic [7:0]      idle_cnt_reg, idle_cnt_next;
`endif

  logic [7:0]      req_byte [NREQ];
  logic            owner_valid;
  logic [7:0]      owner_byte;
  logic            out_free;
  logic            rel_now;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW:0]     scan_sum;

  // Output register can take a new byte when empty or emptying this cycle.
  assign out_free = !out_valid_reg || uart_ready;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_byte[gi]  = req_data[8*gi +: 8];
    assign req_ready[gi] = grant_reg[gi] && out_free;
  end

  assign owner_valid = req_valid[owner_reg];
  assign owner_byte  = req_byte[owner_reg];

  // First valid requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) scan_sum = scan_sum - (PW+1)'(NREQ);
      if (!pick_found && req_valid[scan_sum[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    burst_cnt_next = burst_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
`ifdef BOA_UART_ARB_TIMEOUT_EN
    idle_cnt_next  = idle_cnt_reg;
`endif
    rel_now        = 1'b0;

    if (out_valid_reg && uart_ready) out_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next     = ST_LOCKED;
          owner_next     = pick_idx;
          grant_next     = NREQ'(1) << pick_idx;
          burst_cnt_next = 8'd0;
`ifdef BOA_UART_ARB_TIMEOUT_EN
          idle_cnt_next  = 8'd0;
`endif
        end
      end
      ST_LOCKED: begin
        if (owner_valid && out_free) begin
          out_valid_next = 1'b1;
          out_data_next  = owner_byte;
          burst_cnt_next = burst_cnt_reg + 8'd1;
`ifdef BOA_UART_ARB_TIMEOUT_EN
          idle_cnt_next  = 8'd0;
`endif
          // The releasing byte itself is still sent.
          rel_now = (owner_byte == NEWLINE) || (burst_cnt_reg == BURST_LAST);
        end else if (!owner_valid) begin
`ifdef BOA_UART_ARB_TIMEOUT_EN
          idle_cnt_next = idle_cnt_reg + 8'd1;
          rel_now       = (idle_cnt_next == 8'(IDLE_TIMEOUT));
`else
          rel_now = 1'b1;
`endif
        end
        if (rel_now) begin
          state_next  = ST_IDLE;
          grant_next  = '0;
          rr_ptr_next = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + PW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= 8'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'd0;
`ifdef BOA_UART_ARB_TIMEOUT_EN
      idle_cnt_reg  <= 8'd0;
`endif
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      burst_cnt_reg <= burst_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
`ifdef BOA_UART_ARB_TIMEOUT_EN
      idle_cnt_reg  <= idle_cnt_next;
`endif
    end
  end

  assign uart_we    = out_valid_reg;
  assign uart_wdata = out_data_reg;
  assign grant      = grant_reg;
  assign locked     = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_boa_uart_tx_arbiter.sv
// Randomized and directed bench for boa_uart_tx_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_boa_uart_tx_arbiter;

  localparam int NREQ         = 4;
  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              uart_we;
  logic [7:0]        uart_wdata;
  logic              uart_ready = 1'b1;
  logic [NREQ-1:0]   grant;
  logic              locked;

  boa_uart_tx_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .uart_we(uart_we), .uart_wdata(uart_wdata), .uart_ready(uart_ready),
    .grant(grant), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Requester sources: byte queue plus idle cycles to wait before each byte.
  logic [7:0]      src_data [NREQ][$];
  int              src_gap  [NREQ][$];
  logic [NREQ-1:0] cur_v;
  logic [7:0]      cur_d [NREQ];
  logic [NREQ-1:0] acc;

  // Reference model: owner index (-1 = none), pointer, counters, output queue.
  int         m_owner, m_ptr, m_burst, m_idle;
  logic [7:0] m_outq[$];

  int  scn_cyc;
  int  bp_start, bp_len;
  bit  rand_ready;
  logic [7:0] out_log[$];
  logic [NREQ-1:0] obs_grant [64];
  logic [NREQ-1:0] obs_ready [64];
  logic            obs_we    [64];
  logic            obs_locked[64];
  logic [7:0]      obs_wdata [64];

  task automatic add_line(input int r, input string s, input int gap);
    for (int k = 0; k < s.len(); k++) begin
      src_data[r].push_back(s[k]);
      src_gap[r].push_back(k == 0 ? gap : 0);
    end
  endtask

  function automatic bit scn_idle();
    if (m_owner >= 0 || m_outq.size() != 0 || cur_v != '0) return 1'b0;
    for (int i = 0; i < NREQ; i++) if (src_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset(input bit check_outputs);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      src_data[i].delete();
      src_gap[i].delete();
      cur_d[i] = 8'h00;
    end
    cur_v = '0; acc = '0; req_valid = '0; req_data = '0; uart_ready = 1'b1;
    @(posedge clk); #1;
    if (check_outputs) begin
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_locked", 32'(locked), 32'h0);
      check_eq("rst_req_ready", 32'(req_ready), 32'h0);
      check_eq("rst_uart_we", 32'(uart_we), 32'h0);
      check_eq("rst_uart_wdata", 32'(uart_wdata), 32'h0);
    end
    rst = 1'b0;
    m_owner = -1; m_ptr = 0; m_burst = 0; m_idle = 0;
    m_outq.delete();
    out_log.delete();
    scn_cyc = 0; bp_start = 0; bp_len = 0; rand_ready = 1'b0;
  endtask

  // One clock cycle: drive, sample at the falling edge, advance the model.
  task automatic step();
    logic [NREQ-1:0] exp_grant, exp_ready;
    bit free, rel;
    int nxt;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) cur_v[i] = 1'b0;
      if (!cur_v[i] && src_data[i].size() != 0) begin
        if (src_gap[i][0] > 0) src_gap[i][0] = src_gap[i][0] - 1;
        else begin
          cur_d[i] = src_data[i].pop_front();
          void'(src_gap[i].pop_front());
          cur_v[i] = 1'b1;
        end
      end
      req_data[8*i +: 8] = cur_d[i];
    end
    req_valid = cur_v;
    if (rand_ready) uart_ready = ($urandom_range(0, 3) != 0);
    else uart_ready = !(scn_cyc >= bp_start && scn_cyc < bp_start + bp_len);
    #4;
    free      = (m_outq.size() == 0) || uart_ready;
    exp_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    exp_ready = free ? exp_grant : '0;
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("locked", 32'(locked), 32'(m_owner >= 0));
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("uart_we", 32'(uart_we), 32'(m_outq.size() != 0));
    if (m_outq.size() != 0) check_eq("uart_wdata", 32'(uart_wdata), 32'(m_outq[0]));
    if (scn_cyc < 64) begin
      obs_grant[scn_cyc] = grant; obs_ready[scn_cyc] = req_ready; obs_we[scn_cyc] = uart_we;
      obs_locked[scn_cyc] = locked; obs_wdata[scn_cyc] = uart_wdata;
    end
    if (uart_we && uart_ready) begin
      out_log.push_back(uart_wdata);
      $display("cyc=%0d uart write 0x%02h grant=%b", scn_cyc, uart_wdata, grant);
    end

    acc = '0;
    rel = 1'b0;
    if (m_outq.size() != 0 && uart_ready) void'(m_outq.pop_front());
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        nxt = (m_ptr + k) % NREQ;
        if (cur_v[nxt]) begin
          m_owner = nxt; m_burst = 0; m_idle = 0;
          break;
        end
      end
    end else if (cur_v[m_owner]) begin
      if (free) begin
        acc[m_owner] = 1'b1;
        m_outq.push_back(cur_d[m_owner]);
        m_burst++;
        m_idle = 0;
        rel = (cur_d[m_owner] == 8'h0A) || (m_burst == MAX_BURST);
      end
    end else begin
`ifdef BOA_UART_ARB_TIMEOUT_EN
      m_idle++;
      rel = (m_idle == IDLE_TIMEOUT);
`else
      rel = 1'b1;
`endif
    end
    if (rel) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
    @(posedge clk); #1;
    scn_cyc++;
  endtask

  task automatic run_scn(input string name, input int budget);
    int n = 0;
    while (!scn_idle() && n < budget) begin
      step();
      n++;
    end
    check_eq({name, "_finished"}, 32'(scn_idle()), 32'h1);
  endtask

  task automatic check_log(input string name, input string want);
    check_eq({name, "_len"}, 32'(out_log.size()), 32'(want.len()));
    for (int k = 0; k < want.len() && k < out_log.size(); k++)
      check_eq(name, 32'(out_log[k]), 32'(want[k]));
  endtask

  initial begin
    apply_reset(1'b1);

    // Single line, with the exact latency timeline.
    add_line(1, "AB\n", 0);
    run_scn("single", 40);
    check_eq("single_grant_t1", 32'(obs_grant[1]), 32'h2);
    check_eq("single_ready_t1", 32'(obs_ready[1]), 32'h2);
    check_eq("single_we_t1", 32'(obs_we[1]), 32'h0);
    check_eq("single_wdata_t2", 32'(obs_wdata[2]), 32'h41);
    check_eq("single_wdata_t3", 32'(obs_wdata[3]), 32'h42);
    check_eq("single_wdata_t4", 32'(obs_wdata[4]), 32'h0A);
    check_eq("single_we_t4", 32'(obs_we[4]), 32'h1);
    check_eq("single_locked_t3", 32'(obs_locked[3]), 32'h1);
    check_eq("single_locked_t4", 32'(obs_locked[4]), 32'h0);
    check_log("single_seq", "AB\n");

    // Contention: 0 before 2, then pointer at 3 puts R ahead of S.
    apply_reset(1'b0);
    add_line(0, "P\n", 0);
    add_line(0, "S\n", 0);
    add_line(2, "Q\n", 0);
    add_line(3, "R\n", 5);
    run_scn("contention", 80);
    check_log("contention_seq", "P\nQ\nR\nS\n");

    // Back-pressure for five cycles mid-line.
    apply_reset(1'b0);
    add_line(1, "HELLO\n", 0);
    bp_start = 4; bp_len = 5;
    run_scn("backpressure", 60);
    for (int c = 4; c < 9; c++) begin
      check_eq("bp_wdata_held", 32'(obs_wdata[c]), 32'h4C);
      check_eq("bp_we_held", 32'(obs_we[c]), 32'h1);
      check_eq("bp_ready_low", 32'(obs_ready[c]), 32'h0);
    end
    check_log("backpressure_seq", "HELLO\n");

    // Burst cap of 4 with requester 0 waiting.
    apply_reset(1'b0);
    add_line(3, "abcdef", 0);
    add_line(0, "Z\n", 2);
    run_scn("burst", 120);
    check_log("burst_seq", "abcdZ\nef");

    // Idle gap inside a line.
    apply_reset(1'b0);
    add_line(0, "A", 0);
    add_line(0, "B\n", 10);
    add_line(1, "W\n", 0);
    run_scn("idle", 120);
`ifdef BOA_UART_ARB_TIMEOUT_EN
    check_log("idle_seq", "AB\nW\n");
`else
    check_log("idle_seq", "AW\nB\n");
`endif

    // Reset in the middle of a burst.
    apply_reset(1'b0);
    add_line(2, "LONGLINE\n", 0);
    for (int c = 0; c < 4; c++) step();
    check_eq("mid_we_before_rst", 32'(uart_we), 32'h1);
    apply_reset(1'b1);
    for (int c = 0; c < 2; c++) step();

    // Randomized traffic with random back-pressure.
    apply_reset(1'b0);
    rand_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 25; k++) begin
        src_data[i].push_back(($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(32, 126)));
        src_gap[i].push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 24)) : 0);
      end
    end
    run_scn("random", 6000);
    check_eq("random_total_bytes", 32'(out_log.size()), 32'(NREQ * 25));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
